// File: rtl/mii_rx_deframe.sv
// MII receive deframer: strips preamble/SFD, emits payload nibbles with the
// trailing FCS withheld, and reports CRC-32, alignment and length status at
// end of frame.
// Optional statistics counters are built when MII_RX_DEFRAME_STATS_EN is
// defined; otherwise good_count/bad_count are tied to zero.
module mii_rx_deframe #(
  parameter int MIN_PREAMBLE = 2,
  parameter int MAX_NIBBLES  = 3036,
  parameter int MIN_NIBBLES  = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rxd,
  input  logic        rxdv,
  output logic [3:0]  q,
  output logic        qv,
  output logic        sof,
  output logic        eof,
  output logic        fcs_ok,
  output logic        align_err,
  output logic        len_err,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam int CW = $clog2(MAX_NIBBLES + 2);
  localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_NIBBLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_NIBBLES);
  localparam logic [CW-1:0] CNT_MIN   = CW'(MIN_NIBBLES);
  localparam logic [CW-1:0] CNT_FULL  = CW'(8);
  localparam logic [3:0]    PRE_MIN   = 4'(MIN_PREAMBLE);
  localparam logic [31:0]   CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0]   CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0]   CRC_GOOD  = 32'hDEBB_20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    precount_q, precount_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   crc_q, crc_d;
  logic [31:0]   dline_q, dline_d;
  logic [3:0]    q_q, q_d;
  logic          qv_q, qv_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          fcsOk_q, fcsOk_d;
  logic          alignErr_q, alignErr_d;
  logic          lenErr_q, lenErr_d;

  // Reflected CRC-32 advanced by one nibble, LSB first.
  function automatic logic [31:0] crcNibble(input logic [31:0] cIn, input logic [3:0] d);
    logic [31:0] c;
    c = cIn;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Next-state and output decode; outputs are registered so every pulse is glitch-free.
  always_comb begin
    state_d    = state_q;
    precount_d = precount_q;
    count_d    = count_q;
    crc_d      = crc_q;
    dline_d    = dline_q;
    q_d        = 4'h0;
    qv_d       = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    fcsOk_d    = 1'b0;
    alignErr_d = 1'b0;
    lenErr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxdv) begin
          if (rxd == 4'h5) begin
            state_d    = PRE;
            precount_d = 4'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!rxdv) begin
          state_d = IDLE;
        end else if (rxd == 4'h5) begin
          if (precount_q != 4'hF) precount_d = precount_q + 4'd1;
        end else if (rxd == 4'hD && precount_q >= PRE_MIN) begin
          state_d = DATA;
          count_d = '0;
          crc_d   = CRC_INIT;
          dline_d = '0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rxdv) begin
          crc_d   = crcNibble(crc_q, rxd);
          dline_d = {dline_q[27:0], rxd};
          if (count_q != CNT_SAT) count_d = count_q + CW'(1);
          if (count_q >= CNT_FULL) begin
            q_d   = dline_q[31:28];
            qv_d  = 1'b1;
            sof_d = (count_q == CNT_FULL);
          end
        end else begin
          state_d    = IDLE;
          eof_d      = 1'b1;
          fcsOk_d    = (crc_q == CRC_GOOD);
          alignErr_d = count_q[0];
          lenErr_d   = (count_q < CNT_MIN) || (count_q > CNT_MAX);
        end
      end
      DROP: begin
        if (!rxdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      precount_q <= 4'd0;
      count_q    <= '0;
      crc_q      <= CRC_INIT;
      dline_q    <= '0;
      q_q        <= 4'h0;
      qv_q       <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      fcsOk_q    <= 1'b0;
      alignErr_q <= 1'b0;
      lenErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      precount_q <= precount_d;
      count_q    <= count_d;
      crc_q      <= crc_d;
      dline_q    <= dline_d;
      q_q        <= q_d;
      qv_q       <= qv_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      fcsOk_q    <= fcsOk_d;
      alignErr_q <= alignErr_d;
      lenErr_q   <= lenErr_d;
    end
  end

  assign q         = q_q;
  assign qv        = qv_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign fcs_ok    = fcsOk_q;
  assign align_err = alignErr_q;
  assign len_err   = lenErr_q;

`ifdef MII_RX_DEFRAME_STATS_EN
  logic [15:0] goodCount_q, goodCount_d;
  logic [15:0] badCount_q, badCount_d;

  // Classify each frame as it ends so the counts move together with eof.
  always_comb begin
    goodCount_d = goodCount_q;
    badCount_d  = badCount_q;
    if (eof_d) begin
      if (fcsOk_d && !alignErr_d && !lenErr_d) goodCount_d = goodCount_q + 16'd1;
      else                                     badCount_d  = badCount_q + 16'd1;
    end
  end

  // Wrapping frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      goodCount_q <= 16'd0;
      badCount_q  <= 16'd0;
    end else begin
      goodCount_q <= goodCount_d;
      badCount_q  <= badCount_d;
    end
  end

  assign good_count = goodCount_q;
  assign bad_count  = badCount_q;
`else
  assign good_count = 16'd0;
  assign bad_count  = 16'd0;
`endif

endmodule

// File: tb/tb_mii_rx_deframe.sv
// Scoreboard testbench for mii_rx_deframe: expected payload nibbles and
// end-of-frame status are queued as frames are driven and checked as the
// deframer produces them.
module tb_mii_rx_deframe;

  localparam int MAXN = 3036;
  localparam int MINN = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rxd = 4'h0;
  logic        rxdv = 1'b0;
  logic [3:0]  q;
  logic        qv, sof, eof, fcs_ok, align_err, len_err;
  logic [15:0] good_count, bad_count;

  int checks = 0;
  int failures = 0;

  typedef struct {logic [3:0] nib; logic sof;} qExp_t;
  typedef struct {logic fcsOk; logic align; logic len;} eofExp_t;
  qExp_t   expQ[$];
  eofExp_t eofQ[$];
  logic [3:0] txQ[$];
  logic [15:0] goodModel = 16'd0;
  logic [15:0] badModel  = 16'd0;

  mii_rx_deframe dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rxdv(rxdv),
    .q(q), .qv(qv), .sof(sof), .eof(eof),
    .fcs_ok(fcs_ok), .align_err(align_err), .len_err(len_err),
    .good_count(good_count), .bad_count(bad_count)
  );

  // Free-running receive clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Reference CRC over the first n nibbles of txQ, bit-serial, LSB first.
  function automatic logic [31:0] crcOfTx(input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) begin
        fb = c[0] ^ txQ[k][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return c;
  endfunction

  task automatic appendFcs();
    logic [31:0] fcs;
    fcs = ~crcOfTx(txQ.size());
    for (int i = 0; i < 8; i++) txQ.push_back(fcs[4*i +: 4]);
  endtask

  task automatic fillBytes(input int nBytes, input bit randomData);
    txQ.delete();
    for (int i = 0; i < 2 * nBytes; i++) txQ.push_back(randomData ? 4'($urandom_range(0, 15)) : 4'h0);
  endtask

  task automatic driveNibble(input logic v, input logic [3:0] d);
    @(posedge clk);
    #1;
    rxdv = v;
    rxd  = d;
  endtask

  // Queue expectations for txQ, then drive preamble, SFD, txQ and one idle cycle.
  task automatic applyStimulus(input int preLen);
    int n, cnt;
    eofExp_t e;
    n = txQ.size();
    for (int i = 0; i < n - 8; i++) expQ.push_back('{nib: txQ[i], sof: (i == 0)});
    cnt = (n > MAXN) ? MAXN + 1 : n;
    e.fcsOk = (crcOfTx(n) == 32'hDEBB_20E3);
    e.align = cnt[0];
    e.len   = (cnt < MINN) || (cnt > MAXN);
    eofQ.push_back(e);
    for (int i = 0; i < preLen; i++) driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'hD);
    for (int i = 0; i < n; i++) driveNibble(1'b1, txQ[i]);
    driveNibble(1'b0, 4'h0);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && (expQ.size() != 0 || eofQ.size() != 0); i++) @(negedge clk);
    checkOutput("expQEmpty", 64'(expQ.size()), 64'd0);
    checkOutput("eofQEmpty", 64'(eofQ.size()), 64'd0);
  endtask

  // Output monitor, sampling on the falling edge.
  initial begin
    qExp_t   qe;
    eofExp_t ee;
    forever begin
      @(negedge clk);
      if (qv) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedQv", 64'd1, 64'd0);
        end else begin
          qe = expQ.pop_front();
          checkOutput("q", 64'(q), 64'(qe.nib));
          checkOutput("sof", 64'(sof), 64'(qe.sof));
          checkOutput("flagsOffEof", 64'({fcs_ok, align_err, len_err}), 64'd0);
        end
      end else if (sof) begin
        checkOutput("sofWithoutQv", 64'd1, 64'd0);
      end
      if (eof) begin
        if (eofQ.size() == 0) begin
          checkOutput("unexpectedEof", 64'd1, 64'd0);
        end else begin
          ee = eofQ.pop_front();
          checkOutput("fcsOk", 64'(fcs_ok), 64'(ee.fcsOk));
          checkOutput("alignErr", 64'(align_err), 64'(ee.align));
          checkOutput("lenErr", 64'(len_err), 64'(ee.len));
          checkOutput("eofQvLow", 64'(qv), 64'd0);
`ifdef MII_RX_DEFRAME_STATS_EN
          if (ee.fcsOk && !ee.align && !ee.len) goodModel = goodModel + 16'd1;
          else                                  badModel  = badModel + 16'd1;
`endif
          checkOutput("goodCount", 64'(good_count), 64'(goodModel));
          checkOutput("badCount", 64'(bad_count), 64'(badModel));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutputs",
                64'({q, qv, sof, eof, fcs_ok, align_err, len_err, good_count, bad_count}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Minimum-size valid frame of zeros.
    fillBytes(60, 1'b0);
    appendFcs();
    applyStimulus(15);
    waitDrain(50);

    // Same frame with the tenth payload nibble corrupted.
    fillBytes(60, 1'b0);
    appendFcs();
    txQ[9] = 4'h1;
    applyStimulus(15);
    waitDrain(50);

    // Valid frame followed by one stray nibble.
    fillBytes(60, 1'b0);
    appendFcs();
    txQ.push_back(4'h3);
    applyStimulus(15);
    waitDrain(50);

    // Bad preamble nibble, then a preamble that is too short.
    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'h7);
    for (int i = 0; i < 20; i++) driveNibble(1'b1, 4'h0);
    driveNibble(1'b0, 4'h0);
    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'hD);
    for (int i = 0; i < 20; i++) driveNibble(1'b1, 4'h0);
    driveNibble(1'b0, 4'h0);
    waitDrain(20);

    // Runt frame with correct FCS.
    fillBytes(12, 1'b1);
    appendFcs();
    applyStimulus(7);
    waitDrain(50);

    // Random-payload valid frame at a minimal preamble.
    fillBytes(64, 1'b1);
    appendFcs();
    applyStimulus(2);
    waitDrain(50);

    // Oversize frame; the saturated nibble count is odd.
    fillBytes(1520, 1'b0);
    appendFcs();
    applyStimulus(7);
    waitDrain(50);

    // Reset in the middle of a frame after twelve payload nibbles have left.
    for (int i = 0; i < 12; i++) expQ.push_back('{nib: 4'hA, sof: (i == 0)});
    for (int i = 0; i < 7; i++) driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'hD);
    for (int i = 0; i < 20; i++) driveNibble(1'b1, 4'hA);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    goodModel = 16'd0;
    badModel  = 16'd0;
    #1;
    checkOutput("resetMidOutputs",
                64'({q, qv, sof, eof, fcs_ok, align_err, len_err, good_count, bad_count}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) driveNibble(1'b1, 4'hA);
    driveNibble(1'b0, 4'h0);
    driveNibble(1'b0, 4'h0);
    waitDrain(20);

    // Valid frame after the reset.
    fillBytes(64, 1'b1);
    appendFcs();
    applyStimulus(7);
    waitDrain(50);

    // Back-to-back frames separated by a single idle cycle.
    fillBytes(60, 1'b1);
    appendFcs();
    applyStimulus(7);
    fillBytes(62, 1'b1);
    appendFcs();
    applyStimulus(7);
    waitDrain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
